// File: rtl/eq_bist_ctrl.sv
// Built-in self-test sequencer for a 2-bit equality comparator.
// Sweeps all 16 operand combinations {a,b,c,d}, holds each one for HOLD
// cycles, samples cmp_s on the last hold cycle, and counts matches and
// mismatches against the golden function s = (a==c)&(b==d).
// Handshake: start (accepted only in IDLE), busy during the sweep, and a
// one-cycle done pulse carrying a registered pass flag.

module eq_bist_ctrl #(
    parameter int unsigned HOLD = 4          // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cmp_s,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [3:0] vec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] match_cnt,
    output logic [4:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last hold count before the sample edge of each vector.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state, state_nxt;
    logic [3:0] hold, hold_nxt;
    logic [3:0] vec_nxt;
    logic [4:0] match_nxt, err_nxt;
    logic       pass_nxt;
    logic       golden;

    // Next-state and next-datapath logic for the sweep sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        state_nxt = state;
        hold_nxt  = hold;
        vec_nxt   = vec;
        match_nxt = match_cnt;
        err_nxt   = err_cnt;
        pass_nxt  = pass;
        golden    = (vec[3] == vec[1]) & (vec[2] == vec[0]);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    hold_nxt  = 4'd0;
                    vec_nxt   = 4'd0;
                    match_nxt = 5'd0;
                    err_nxt   = 5'd0;
                    pass_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                if (hold != HOLD_LAST) begin
                    hold_nxt = hold + 4'd1;
                end else begin
                    // Sample edge: the vector has been stable for HOLD cycles.
                    match_nxt = match_cnt + {4'd0, cmp_s};
                    err_nxt   = err_cnt + {4'd0, cmp_s ^ golden};
                    hold_nxt  = 4'd0;
                    if (vec == 4'd15) begin
                        state_nxt = S_DONE;
                        vec_nxt   = 4'd0;
                        // Includes the last vector's contribution.
                        pass_nxt  = (err_nxt == 5'd0);
                    end else begin
                        vec_nxt = vec + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= S_IDLE;
            hold      <= 4'd0;
            vec       <= 4'd0;
            {a, b, c, d} <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            match_cnt <= 5'd0;
            err_cnt   <= 5'd0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            vec       <= vec_nxt;
            {a, b, c, d} <= vec_nxt;
            busy      <= (state_nxt == S_RUN);
            done      <= (state_nxt == S_DONE);
            pass      <= pass_nxt;
            match_cnt <= match_nxt;
            err_cnt   <= err_nxt;
        end
    end

endmodule

// File: doc/eq_bist_ctrl.md
Name: eq_bist_ctrl

Overview:
Built-in self-test sequencer for the 2-bit equality comparator (s = (a==c)&(b==d)).
- Drives all 16 input combinations into one comparator instance and holds each combination for HOLD cycles.
- Samples the comparator output, checks it against the golden function, counts matches and mismatches, and reports pass/fail through a start/busy/done handshake.
- Sits beside the comparator in the lab top level; the comparator has no other user during a run.

Parameters:
HOLD, 4, cycles each vector is held before cmp_s is sampled (legal: 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  run request; level-sampled, accepted only in IDLE
cmp_s  input  1  comparator result s
a  output  1  comparator operand a (vec[3])
b  output  1  comparator operand b (vec[2])
c  output  1  comparator operand c (vec[1])
d  output  1  comparator operand d (vec[0])
vec  output  4  current vector index {a,b,c,d}
busy  output  1  high while sweeping (RUN)
done  output  1  one-cycle pulse at end of sweep
pass  output  1  1 when err_cnt==0 at end of the last sweep; holds until the next start
match_cnt  output  5  samples where cmp_s==1
err_cnt  output  5  samples where cmp_s != golden

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-low, rst_n. All outputs are registered.
- Reset value, all outputs: 0. State after reset: IDLE.
- rst_n low mid-run: aborts at the next edge, returns to IDLE, zeroes all outputs. No done pulse.
- States:
  - IDLE: operands 0, busy 0.
  - RUN: busy 1.
  - DONE: one cycle, done 1, busy 0, operands 0.
- IDLE -> RUN: at edge E0 with start=1.
  - vec<=0, hold<=0.
  - match_cnt<=0, err_cnt<=0, pass<=0.
- RUN, each edge:
  - If hold != HOLD-1: hold++.
  - Else (sample edge): update counters from cmp_s, then hold<=0.
    - If vec==15: go to DONE.
    - Otherwise: vec++.
- Counter updates at the sample edge:
  - golden = (vec[3]==vec[1]) & (vec[2]==vec[0]).
  - match_cnt += cmp_s.
  - err_cnt += (cmp_s ^ golden).
  - Counters are 5 bits; the maximum is 16, so they never wrap.
- Timing:
  - Vector v is presented from edge E(v*HOLD) up to edge E((v+1)*HOLD).
  - It is sampled at edge E((v+1)*HOLD), giving the comparator HOLD cycles to settle.
  - The last sample is at E(16*HOLD). That same edge enters DONE, registers pass = (final err_cnt==0) including the last vector's contribution, and drives a..d and vec to 0.
  - busy is high for exactly 16*HOLD cycles.
  - done is high for the cycle after E(16*HOLD).
- DONE -> IDLE unconditionally. start is ignored in RUN and DONE. start held high re-launches at the first IDLE edge, one cycle after done falls.
- Outputs after completion: match_cnt, err_cnt and pass hold their final values in IDLE until the next accepted start clears them.
- Golden comparator result: exactly 4 matches, at vec = 0000, 0101, 1010, 1111.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 for 2 cycles with start=1.
   - Required: all outputs 0, busy stays 0 while in reset.
   - Stimulus: release rst_n with start=0.
   - Required: busy stays 0.
2. Correct comparator, HOLD=4:
   - Stimulus: bench models cmp_s=(a==c)&(b==d); one-cycle start pulse.
   - Required: busy high 64 cycles; vec steps 0..15 every 4 cycles; done pulse 1 cycle; match_cnt=4, err_cnt=0, pass=1.
3. Stuck-at-0 comparator (cmp_s=0):
   - Required: match_cnt=0, err_cnt=4, pass=0.
4. Partial comparator (cmp_s=(a==c)):
   - Required: match_cnt=8, err_cnt=4, pass=0.
   - Stimulus: rerun with the correct model.
   - Required: counters cleared at start, final pass=1.
5. start held high continuously, HOLD=1:
   - Required: busy high 16 cycles, done 1 cycle, busy re-asserts one cycle after done.
   - Required: only one run per sweep; no start accepted while busy.
6. Reset mid-run:
   - Stimulus: rst_n=0 for one edge while vec=7.
   - Required: at the next edge all outputs 0, no done pulse.
   - Stimulus: a new start with the correct model.
   - Required: full 16-vector sweep, pass=1.
